fb_bmp_writer: RTL and testbench

- Write side of the 400x300 12-bit frame buffer that the VGA scan-out reads.
- Consumes a byte stream of a 24-bit uncompressed BMP file (delivered by the SD/SPI reader) through a valid/ready handshake.
- Skips the file header, packs each B,G,R byte triple into one RGB444 word and writes it to BRAM port A.
- BMP bottom-up row order is flipped so that frame-buffer address ADDR_BASE holds the top-left pixel, matching the scan-out mapping addr = ADDR_BASE + x + y*IMG_W.

---
 rtl/fb_bmp_writer_pkg.sv | 30 +++
 rtl/fb_bmp_writer_if.sv | 28 ++
 rtl/fb_addr_gen.sv | 55 +++++
 rtl/fb_bmp_writer.sv | 119 +++++++++++
 tb/tb_fb_bmp_writer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_bmp_writer_pkg.sv
// Shared frame-buffer geometry, pixel format and writer state encoding.
// The VGA scan-out imports the same package so both sides agree on the address map.
package fb_bmp_writer_pkg;

    localparam int unsigned FB_IMG_W     = 400;
    localparam int unsigned FB_IMG_H     = 300;
    localparam int unsigned FB_HDR_BYTES = 54;
    localparam int unsigned FB_ADDR_W    = 17;
    localparam int unsigned FB_ADDR_BASE = 1;
    localparam int unsigned FB_PIX_W     = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SKIP  = 2'd1,
        PIXEL = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pix_t;

    // Counter width for values 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fb_bmp_writer_if.sv
// Control, byte stream and frame-buffer port A signals of the BMP writer.
interface fb_bmp_writer_if
    import fb_bmp_writer_pkg::*;
#(
    parameter int unsigned ADDR_W = FB_ADDR_W
);

    logic                start;
    logic [7:0]          in_data;
    logic                in_valid;
    logic                in_ready;
    logic                wea;
    logic [ADDR_W-1:0]   addra;
    logic [FB_PIX_W-1:0] dina;
    logic                busy;
    logic                done;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, wea, addra, dina, busy, done
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, wea, addra, dina, busy, done
    );

endinterface

// File: rtl/fb_addr_gen.sv
// Column/row walker producing the frame-buffer address of the next pixel,
// visiting screen rows bottom-up to undo the BMP row order.
module fb_addr_gen
    import fb_bmp_writer_pkg::*;
#(
    parameter int unsigned IMG_W     = FB_IMG_W,
    parameter int unsigned IMG_H     = FB_IMG_H,
    parameter int unsigned ADDR_W    = FB_ADDR_W,
    parameter int unsigned ADDR_BASE = FB_ADDR_BASE
) (
    input  logic              CLK,
    input  logic              Rst_n,
    input  logic              clear,
    input  logic              step,
    output logic [ADDR_W-1:0] addr_c,
    output logic              last_c
);

    localparam int unsigned COL_W = cnt_w(IMG_W);
    localparam int unsigned ROW_W = cnt_w(IMG_H);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] ROW_BASE0 = ADDR_W'(ADDR_BASE + (IMG_H - 1) * IMG_W);
    localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(IMG_W);

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] row_base;

    // Stepping is frozen on the final pixel so row_base cannot wrap below ADDR_BASE
    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            col      <= '0;
            row      <= '0;
            row_base <= '0;
        end else if (clear) begin
            col      <= '0;
            row      <= '0;
            row_base <= ROW_BASE0;
        end else if (step && !last_c) begin
            if (col == COL_LAST) begin
                col      <= '0;
                row      <= row + ROW_W'(1);
                row_base <= row_base - STRIDE;
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    assign addr_c = row_base + ADDR_W'(col);
    assign last_c = (col == COL_LAST) && (row == ROW_LAST);

endmodule

// File: rtl/fb_bmp_writer.sv
// Streams a 24-bit BMP into the RGB444 frame buffer: drops the header,
// packs B,G,R triples and writes them top row first.
module fb_bmp_writer
    import fb_bmp_writer_pkg::*;
#(
    parameter int unsigned IMG_W     = FB_IMG_W,
    parameter int unsigned IMG_H     = FB_IMG_H,
    parameter int unsigned HDR_BYTES = FB_HDR_BYTES,
    parameter int unsigned ADDR_W    = FB_ADDR_W,
    parameter int unsigned ADDR_BASE = FB_ADDR_BASE
) (
    input  logic            CLK,
    input  logic            Rst_n,
    fb_bmp_writer_if.slave  bus
);

    localparam int unsigned          SKIP_W    = cnt_w(HDR_BYTES + 1);
    localparam logic [SKIP_W-1:0]    SKIP_LAST = SKIP_W'((HDR_BYTES == 0) ? 0 : HDR_BYTES - 1);

    state_t            state;
    state_t            state_nx;
    logic              xfer_c;
    logic              last_c;
    logic              ld_c;
    logic              skip_inc_c;
    logic              byte_step_c;
    logic              pix_wr_c;
    logic [SKIP_W-1:0] skip_cnt;
    logic [1:0]        byte_idx;
    logic [3:0]        b_hi;
    logic [3:0]        g_hi;
    logic [ADDR_W-1:0] addr_c;
    pix_t              pix_c;

    assign xfer_c = bus.in_valid && bus.in_ready;
    assign pix_c  = '{r: bus.in_data[7:4], g: g_hi, b: b_hi};

    fb_addr_gen #(
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .ADDR_W    (ADDR_W),
        .ADDR_BASE (ADDR_BASE)
    ) u_addr_gen (
        .CLK    (CLK),
        .Rst_n  (Rst_n),
        .clear  (ld_c),
        .step   (pix_wr_c),
        .addr_c (addr_c),
        .last_c (last_c)
    );

    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (bus.start) state_nx = (HDR_BYTES == 0) ? PIXEL : SKIP;
            SKIP:  if (xfer_c && (skip_cnt == SKIP_LAST)) state_nx = PIXEL;
            PIXEL: if (xfer_c && (byte_idx == 2'd2) && last_c) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ld_c        = 1'b0;
        skip_inc_c  = 1'b0;
        byte_step_c = 1'b0;
        pix_wr_c    = 1'b0;
        case (state)
            IDLE:  ld_c = bus.start;
            SKIP:  skip_inc_c = xfer_c;
            PIXEL: begin
                byte_step_c = xfer_c;
                pix_wr_c    = xfer_c && (byte_idx == 2'd2);
            end
            default: ;
        endcase
    end

    // Datapath and registered outputs; addra/dina only move on a pixel write
    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            skip_cnt     <= '0;
            byte_idx     <= '0;
            b_hi         <= '0;
            g_hi         <= '0;
            bus.in_ready <= 1'b0;
            bus.wea      <= 1'b0;
            bus.addra    <= '0;
            bus.dina     <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            if (ld_c) begin
                skip_cnt <= '0;
                byte_idx <= '0;
            end
            if (skip_inc_c) skip_cnt <= skip_cnt + SKIP_W'(1);
            if (byte_step_c) begin
                byte_idx <= (byte_idx == 2'd2) ? 2'd0 : byte_idx + 2'd1;
                if (byte_idx == 2'd0) b_hi <= bus.in_data[7:4];
                if (byte_idx == 2'd1) g_hi <= bus.in_data[7:4];
            end
            bus.wea <= pix_wr_c;
            if (pix_wr_c) begin
                bus.addra <= addr_c;
                bus.dina  <= pix_c;
            end
            bus.in_ready <= (state_nx == SKIP) || (state_nx == PIXEL);
            bus.busy     <= (state_nx != IDLE);
            bus.done     <= (state_nx == DONE);
        end
    end

endmodule

// File: tb/tb_fb_bmp_writer.sv
// Directed bench for fb_bmp_writer: a 4x2 image, a 20x10 headerless image
// and the default 400x300 geometry for the mid-image reset case.
module tb_fb_bmp_writer;

    logic CLK = 1'b0;
    logic Rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 CLK = ~CLK;

    fb_bmp_writer_if bus_s ();
    fb_bmp_writer_if bus_d ();
    fb_bmp_writer_if bus_m ();

    fb_bmp_writer #(.IMG_W(4), .IMG_H(2), .HDR_BYTES(2), .ADDR_W(17), .ADDR_BASE(1))
        u_small (.CLK(CLK), .Rst_n(Rst_n), .bus(bus_s));
    fb_bmp_writer u_dflt (.CLK(CLK), .Rst_n(Rst_n), .bus(bus_d));
    fb_bmp_writer #(.IMG_W(20), .IMG_H(10), .HDR_BYTES(0), .ADDR_W(17), .ADDR_BASE(1))
        u_mid (.CLK(CLK), .Rst_n(Rst_n), .bus(bus_m));

    task automatic test_reset();
        Rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            bus_s.start = i[0]; bus_s.in_valid = ~i[0]; bus_s.in_data = 8'hA5;
            bus_d.start = i[0]; bus_d.in_valid = ~i[0]; bus_d.in_data = 8'h5A;
            #1;
            checks++;
            if ({bus_s.in_ready, bus_s.wea, bus_s.addra, bus_s.dina, bus_s.busy, bus_s.done} !== '0) begin
                failures++;
                $display("FAIL reset_small cyc=%0d rdy=%b wea=%b addra=%0d dina=%h busy=%b done=%b expected all 0",
                         i, bus_s.in_ready, bus_s.wea, bus_s.addra, bus_s.dina, bus_s.busy, bus_s.done);
            end
            checks++;
            if ({bus_d.in_ready, bus_d.wea, bus_d.addra, bus_d.dina, bus_d.busy, bus_d.done} !== '0) begin
                failures++;
                $display("FAIL reset_dflt cyc=%0d rdy=%b wea=%b addra=%0d busy=%b expected all 0",
                         i, bus_d.in_ready, bus_d.wea, bus_d.addra, bus_d.busy);
            end
        end
        @(negedge CLK);
        bus_s.start = 1'b0; bus_s.in_valid = 1'b0;
        bus_d.start = 1'b0; bus_d.in_valid = 1'b0;
        Rst_n = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if ({bus_s.in_ready, bus_s.busy, bus_s.wea} !== 3'b000) begin
            failures++;
            $display("FAIL reset_release rdy/busy/wea=%b expected 000", {bus_s.in_ready, bus_s.busy, bus_s.wea});
        end
    endtask

    // 4x2 image, header AA,BB; gaps randomise in_valid, glitch pulses start mid-load
    task automatic test_small(input bit gaps, input bit glitch, input string tag);
        logic [7:0]  stream [0:25];
        logic [16:0] exp_a  [0:7];
        logic [11:0] exp_d  [0:7];
        logic [16:0] got_a  [0:7];
        logic [11:0] got_d  [0:7];
        int idx, nwr, cyc;
        bit done_seen, done_with_wea;
        bit v;
        exp_a = '{17'd5, 17'd6, 17'd7, 17'd8, 17'd1, 17'd2, 17'd3, 17'd4};
        exp_d = '{12'h111, 12'h111, 12'h111, 12'h111, 12'h111, 12'h221, 12'h222, 12'h222};
        stream[0] = 8'hAA;
        stream[1] = 8'hBB;
        for (int i = 2; i < 26; i++) stream[i] = 8'(8'h10 + i - 2);
        for (int i = 0; i < 8; i++) begin got_a[i] = '0; got_d[i] = '0; end
        idx = 0; nwr = 0; cyc = 0; done_seen = 0; done_with_wea = 0;

        @(negedge CLK); bus_s.start = 1'b1;
        @(negedge CLK); bus_s.start = 1'b0;
        checks++;
        if ({bus_s.busy, bus_s.in_ready} !== 2'b11) begin
            failures++;
            $display("FAIL %s_after_start busy/rdy=%b expected 11", tag, {bus_s.busy, bus_s.in_ready});
        end
        while (cyc < 300) begin
            if (bus_s.wea) begin
                if (nwr < 8) begin got_a[nwr] = bus_s.addra; got_d[nwr] = bus_s.dina; end
                nwr++;
            end
            if (bus_s.done) begin
                done_seen = 1; done_with_wea = bus_s.wea;
                break;
            end
            bus_s.start = glitch && (cyc == 1 || cyc == 12);
            v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus_s.in_valid = v && (idx < 26);
            bus_s.in_data  = (idx < 26) ? stream[idx] : 8'hEE;
            if (bus_s.in_valid && bus_s.in_ready) idx++;
            @(negedge CLK);
            cyc++;
        end
        bus_s.start = 1'b0;
        checks++;
        if (!done_seen) begin
            failures++;
            $display("FAIL %s_timeout done not seen after %0d cycles", tag, cyc);
        end
        checks++;
        if (nwr != 8) begin
            failures++;
            $display("FAIL %s_wr_count got %0d expected 8", tag, nwr);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (got_a[k] !== exp_a[k] || got_d[k] !== exp_d[k]) begin
                failures++;
                $display("FAIL %s_pix%0d addra=%0d dina=%h expected addra=%0d dina=%h",
                         tag, k, got_a[k], got_d[k], exp_a[k], exp_d[k]);
            end
        end
        checks++;
        if (!done_with_wea || bus_s.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_done_cycle wea=%b rdy=%b expected wea=1 rdy=0", tag, done_with_wea, bus_s.in_ready);
        end
        // Offer a byte after DONE: it must stay unconsumed and trigger nothing
        bus_s.in_valid = 1'b1; bus_s.in_data = 8'hEE;
        @(negedge CLK);
        checks++;
        if ({bus_s.busy, bus_s.done, bus_s.wea} !== 3'b000) begin
            failures++;
            $display("FAIL %s_after_done busy/done/wea=%b expected 000", tag, {bus_s.busy, bus_s.done, bus_s.wea});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if ({bus_s.in_ready, bus_s.wea, bus_s.done} !== 3'b000) begin
                failures++;
                $display("FAIL %s_stall%0d rdy/wea/done=%b expected 000", tag, i, {bus_s.in_ready, bus_s.wea, bus_s.done});
            end
        end
        bus_s.in_valid = 1'b0;
    endtask

    // Default geometry: abandon after 100 pixels, then reload from scratch
    task automatic test_mid_reset();
        int idx, nwr, cyc;
        logic [16:0] first_a, last_a;
        logic [11:0] first_d;
        idx = 0; nwr = 0; cyc = 0; first_a = '0; last_a = '0; first_d = '0;
        @(negedge CLK); bus_d.start = 1'b1;
        @(negedge CLK); bus_d.start = 1'b0;
        while (nwr < 100 && cyc < 1000) begin
            if (bus_d.wea) begin
                if (nwr == 0) begin first_a = bus_d.addra; first_d = bus_d.dina; end
                last_a = bus_d.addra;
                nwr++;
            end
            if (nwr == 100) break;
            bus_d.in_valid = 1'b1;
            bus_d.in_data  = (idx < 54) ? 8'h55 : ((idx - 54) % 3 == 0) ? 8'hC4 : ((idx - 54) % 3 == 1) ? 8'h7A : 8'h5E;
            if (bus_d.in_ready) idx++;
            @(negedge CLK);
            cyc++;
        end
        checks++;
        if (nwr != 100 || first_a !== 17'd119601 || first_d !== 12'h57C || last_a !== 17'd119700) begin
            failures++;
            $display("FAIL dflt_first100 n=%0d first=%0d/%h last=%0d expected n=100 first=119601/57c last=119700",
                     nwr, first_a, first_d, last_a);
        end
        Rst_n = 1'b0;
        bus_d.in_valid = 1'b0;
        #1;
        checks++;
        if ({bus_d.in_ready, bus_d.wea, bus_d.addra, bus_d.dina, bus_d.busy, bus_d.done} !== '0) begin
            failures++;
            $display("FAIL dflt_mid_reset rdy=%b wea=%b addra=%0d dina=%h busy=%b expected all 0",
                     bus_d.in_ready, bus_d.wea, bus_d.addra, bus_d.dina, bus_d.busy);
        end
        repeat (2) @(negedge CLK);
        Rst_n = 1'b1;
        @(negedge CLK); bus_d.start = 1'b1;
        @(negedge CLK); bus_d.start = 1'b0;
        idx = 0; nwr = 0; cyc = 0;
        while (nwr == 0 && cyc < 200) begin
            if (bus_d.wea) begin first_a = bus_d.addra; first_d = bus_d.dina; nwr++; break; end
            bus_d.in_valid = 1'b1;
            bus_d.in_data  = (idx < 54) ? 8'hFF : (idx == 54) ? 8'h21 : (idx == 55) ? 8'h93 : 8'hE7;
            if (bus_d.in_ready) idx++;
            @(negedge CLK);
            cyc++;
        end
        checks++;
        if (nwr != 1 || first_a !== 17'd119601 || first_d !== 12'hE92) begin
            failures++;
            $display("FAIL dflt_restart n=%0d addra=%0d dina=%h expected n=1 addra=119601 dina=e92",
                     nwr, first_a, first_d);
        end
        bus_d.in_valid = 1'b0;
        Rst_n = 1'b0;
        repeat (2) @(negedge CLK);
        Rst_n = 1'b1;
        @(negedge CLK);
    endtask

    // 20x10 image, no header: full coverage of the frame with a per-pixel model
    task automatic test_full_headerless();
        bit seen [0:255];
        int idx, nwr, cyc, ndone, bad, dup, k, mn, mx;
        logic [16:0] ea;
        logic [11:0] ed;
        logic [7:0]  bb, bg, br;
        idx = 0; nwr = 0; cyc = 0; ndone = 0; bad = 0; dup = 0; mn = 1 << 20; mx = -1;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        @(negedge CLK); bus_m.start = 1'b1;
        @(negedge CLK); bus_m.start = 1'b0;
        checks++;
        if ({bus_m.busy, bus_m.in_ready} !== 2'b11) begin
            failures++;
            $display("FAIL full_after_start busy/rdy=%b expected 11", {bus_m.busy, bus_m.in_ready});
        end
        while (cyc < 2000) begin
            if (bus_m.wea) begin
                k  = nwr;
                ea = 17'(1 + (9 - k / 20) * 20 + k % 20);
                bb = 8'(k * 3 * 29 + 7);
                bg = 8'((k * 3 + 1) * 29 + 7);
                br = 8'((k * 3 + 2) * 29 + 7);
                ed = {br[7:4], bg[7:4], bb[7:4]};
                if (bus_m.addra !== ea || bus_m.dina !== ed) begin
                    bad++;
                    if (bad < 4)
                        $display("FAIL full_pix%0d addra=%0d dina=%h expected addra=%0d dina=%h",
                                 k, bus_m.addra, bus_m.dina, ea, ed);
                end
                if (int'(bus_m.addra) < mn) mn = int'(bus_m.addra);
                if (int'(bus_m.addra) > mx) mx = int'(bus_m.addra);
                if (bus_m.addra < 17'd256) begin
                    if (seen[bus_m.addra[7:0]]) dup++;
                    seen[bus_m.addra[7:0]] = 1'b1;
                end
                nwr++;
            end
            if (bus_m.done) ndone++;
            if (ndone != 0 && !bus_m.done && !bus_m.busy) break;
            bus_m.in_valid = (cyc % 4 != 3) && (idx < 600);
            bus_m.in_data  = 8'(idx * 29 + 7);
            if (bus_m.in_valid && bus_m.in_ready) idx++;
            @(negedge CLK);
            cyc++;
        end
        bus_m.in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL full_pixels %0d wrong writes expected 0", bad);
        end
        checks++;
        if (nwr != 200 || ndone != 1) begin
            failures++;
            $display("FAIL full_counts writes=%0d done=%0d expected 200 and 1", nwr, ndone);
        end
        checks++;
        if (mn != 1 || mx != 200 || dup != 0) begin
            failures++;
            $display("FAIL full_range min=%0d max=%0d dups=%0d expected 1 200 0", mn, mx, dup);
        end
    endtask

    initial begin
        bus_s.start = 1'b0; bus_s.in_valid = 1'b0; bus_s.in_data = '0;
        bus_d.start = 1'b0; bus_d.in_valid = 1'b0; bus_d.in_data = '0;
        bus_m.start = 1'b0; bus_m.in_valid = 1'b0; bus_m.in_data = '0;
        test_reset();
        test_small(1'b0, 1'b0, "small");
        test_small(1'b1, 1'b0, "gaps");
        test_small(1'b0, 1'b1, "glitch");
        test_mid_reset();
        test_full_headerless();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
